accu_diff: RTL and testbench

Decimating, saturating differentiator that reverses the codebase's scaled accumulator. It takes a stream of `SIZE`-bit accumulator samples, forms the difference across every `DECIM` accepted samples, and removes the ×16 input scaling by an arithmetic right shift. It saturates the result to `OUT_WIDTH` bits and delivers it over a valid/ready output register. It sits on the readback side of the accumulator path: it recovers the rate (sum of `IN` values) from logged or transmitted `ACCU` samples.

---
 rtl/accu_pkg.sv | 15 +
 rtl/accu_diff_if.sv | 29 ++
 rtl/sat_shift.sv | 32 +++
 rtl/accu_diff.sv | 92 +++++++++
 tb/tb_accu_diff.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accu_pkg.sv
// Shared constants and types for the scaled accumulator path and its readback blocks.
package accu_pkg;

  localparam int unsigned ACCU_SIZE      = 26;
  localparam int unsigned ACCU_IN_WIDTH  = 15;
  localparam int unsigned ACCU_SHIFT     = 4;
  localparam int unsigned ACCU_LIMIT     = 18849555;
  localparam int unsigned DIFF_DECIM_MAX = 256;

  typedef enum logic {
    PRIME,
    RUN
  } diff_state_t;

endpackage

// File: rtl/accu_diff_if.sv
// Sample stream in, valid/ready result out, plus overrun status for the differentiator.
interface accu_diff_if import accu_pkg::*; #(
  parameter int unsigned SIZE      = ACCU_SIZE,
  parameter int unsigned OUT_WIDTH = ACCU_IN_WIDTH
);

  logic                        in_valid;
  logic signed [SIZE-1:0]      in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        out_inexact;
  logic                        overrun;
  logic                        clr_overrun;

  // Sample producer and result consumer
  modport master (
    output in_valid, in_data, out_ready, clr_overrun,
    input  out_valid, out_data, out_sat, out_inexact, overrun
  );

  // Differentiator
  modport slave (
    input  in_valid, in_data, out_ready, clr_overrun,
    output out_valid, out_data, out_sat, out_inexact, overrun
  );

endinterface

// File: rtl/sat_shift.sv
// Arithmetic right shift (floor) followed by a clip to a signed OUT_W range.
module sat_shift #(
  parameter int unsigned IN_W  = 27,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned OUT_W = 15
) (
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] q_c,
  output logic                    sat_c,
  output logic                    inexact_c
);

  // Bits above the output sign bit must all equal it for the value to fit.
  localparam int unsigned TOP_W = IN_W - OUT_W + 1;

  logic signed [IN_W-1:0] shifted;
  logic [TOP_W-1:0]       top;

  // Shift, detect out-of-range and discarded fraction, then clip.
  always_comb begin
    shifted   = d >>> SHIFT;
    top       = shifted[IN_W-1 -: TOP_W];
    inexact_c = |d[SHIFT-1:0];
    sat_c     = (top != '0) && (top != '1);
    if (sat_c) begin
      q_c = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      q_c = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/accu_diff.sv
// Decimating saturating differentiator: recovers the input rate from accumulator samples.
module accu_diff import accu_pkg::*; #(
  parameter int unsigned SIZE      = ACCU_SIZE,
  parameter int unsigned OUT_WIDTH = ACCU_IN_WIDTH,
  parameter int unsigned SHIFT     = ACCU_SHIFT,
  parameter int unsigned DECIM     = 1
) (
  input logic        clk,
  input logic        rst,
  accu_diff_if.slave bus
);

  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned D_W   = SIZE + 1;

  diff_state_t                 state;
  logic [CNT_W-1:0]            cnt;
  logic signed [SIZE-1:0]      prev;
  logic                        valid_q;
  logic signed [OUT_WIDTH-1:0] data_q;
  logic                        sat_q;
  logic                        inexact_q;
  logic                        overrun_q;

  logic                        tap_c;
  logic                        result_c;
  logic signed [D_W-1:0]       diff_c;
  logic signed [OUT_WIDTH-1:0] res_data_c;
  logic                        res_sat_c;
  logic                        res_inexact_c;

  // Tap detection and one-bit-wider difference so the subtraction cannot wrap.
  always_comb begin
    tap_c    = bus.in_valid && (cnt == CNT_W'(DECIM - 1));
    result_c = tap_c && (state == RUN);
    diff_c   = {bus.in_data[SIZE-1], bus.in_data} - {prev[SIZE-1], prev};
  end

  sat_shift #(
    .IN_W  (D_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_WIDTH)
  ) u_sat_shift (
    .d         (diff_c),
    .q_c       (res_data_c),
    .sat_c     (res_sat_c),
    .inexact_c (res_inexact_c)
  );

  // Counter, prime/run state, tap register and output register with sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PRIME;
      cnt       <= '0;
      prev      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      inexact_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        cnt <= tap_c ? '0 : cnt + CNT_W'(1);
      end
      if (tap_c) begin
        prev  <= bus.in_data;
        state <= RUN;
      end
      if (result_c) begin
        data_q    <= res_data_c;
        sat_q     <= res_sat_c;
        inexact_q <= res_inexact_c;
        valid_q   <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // A fresh overwrite beats a simultaneous clear.
      if (result_c && valid_q && !bus.out_ready) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_sat     = sat_q;
  assign bus.out_inexact = inexact_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_accu_diff.sv
// Bench for accu_diff: DECIM=1 and DECIM=4 instances, vector table plus scoreboard.
module tb_accu_diff;
  import accu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  accu_diff_if #(.SIZE(ACCU_SIZE), .OUT_WIDTH(ACCU_IN_WIDTH)) b1 ();
  accu_diff_if #(.SIZE(ACCU_SIZE), .OUT_WIDTH(ACCU_IN_WIDTH)) b4 ();

  accu_diff #(.SIZE(ACCU_SIZE), .OUT_WIDTH(ACCU_IN_WIDTH), .SHIFT(ACCU_SHIFT), .DECIM(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  accu_diff #(.SIZE(ACCU_SIZE), .OUT_WIDTH(ACCU_IN_WIDTH), .SHIFT(ACCU_SHIFT), .DECIM(4))
    u4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct packed {
    logic [14:0] data;
    logic        sat;
    logic        inex;
  } res_t;

  typedef struct {
    int s;
    bit has;
    int data;
    bit sat;
    bit inex;
  } vec_t;

  res_t sb0[$];
  res_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  bit   primed [2];
  int   prev_m [2];
  int   cnt_m  [2];
  int   decim_m[2] = '{1, 4};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor division by 16 and clip to 15-bit signed.
  function automatic res_t model_calc(input int d);
    int   q;
    res_t r;
    q = d / 16;
    if ((d % 16) != 0 && d < 0) q = q - 1;
    r.inex = ((d % 16) != 0);
    r.sat  = 1'b0;
    if (q > 16383) begin
      r.data = 15'h3FFF;
      r.sat  = 1'b1;
    end else if (q < -16384) begin
      r.data = 15'h4000;
      r.sat  = 1'b1;
    end else begin
      r.data = 15'(q);
    end
    return r;
  endfunction

  task automatic model_step(input int w, input int s);
    res_t r;
    if (cnt_m[w] == decim_m[w] - 1) begin
      cnt_m[w] = 0;
      if (primed[w]) begin
        r = model_calc(s - prev_m[w]);
        if (w == 0) sb0.push_back(r);
        else        sb1.push_back(r);
      end
      primed[w] = 1'b1;
      prev_m[w] = s;
    end else begin
      cnt_m[w]++;
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      primed[w] = 1'b0;
      prev_m[w] = 0;
      cnt_m[w]  = 0;
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic drive(input int w, input bit v, input int s);
    if (w == 0) begin
      b1.in_valid = v;
      b1.in_data  = 26'(s);
    end else begin
      b4.in_valid = v;
      b4.in_data  = 26'(s);
    end
    if (v) model_step(w, s);
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b4.in_valid = 1'b0;
  endtask

  // Scoreboard pop on every handshake of the DECIM=1 instance.
  always @(negedge clk) begin
    res_t e;
    if (rst && b1.out_valid && b1.out_ready) begin
      if (sb0.size() == 0) begin
        chk("u1_unexpected_result", int'(b1.out_data), 99999);
      end else begin
        e = sb0.pop_front();
        chk("u1_sb_data", int'(b1.out_data), int'($signed(e.data)));
        chk("u1_sb_sat", int'(b1.out_sat), int'(e.sat));
        chk("u1_sb_inexact", int'(b1.out_inexact), int'(e.inex));
      end
    end
  end

  // Scoreboard pop on every handshake of the DECIM=4 instance.
  always @(negedge clk) begin
    res_t e;
    if (rst && b4.out_valid && b4.out_ready) begin
      if (sb1.size() == 0) begin
        chk("u4_unexpected_result", int'(b4.out_data), 99999);
      end else begin
        e = sb1.pop_front();
        chk("u4_sb_data", int'(b4.out_data), int'($signed(e.data)));
        chk("u4_sb_sat", int'(b4.out_sat), int'(e.sat));
        chk("u4_sb_inexact", int'(b4.out_inexact), int'(e.inex));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vec_t tbl[17];
    int   s4;
    bit   tap;

    tbl[0]  = '{0,         0, 0,      0, 0};
    tbl[1]  = '{160,       1, 10,     0, 0};
    tbl[2]  = '{320,       1, 10,     0, 0};
    tbl[3]  = '{1000,      1, 42,     0, 1};
    tbl[4]  = '{885,       1, -8,     0, 1};
    tbl[5]  = '{-18849555, 1, -16384, 1, 1};
    tbl[6]  = '{18849555,  1, 16383,  1, 1};
    tbl[7]  = '{-18849555, 1, -16384, 1, 1};
    tbl[8]  = '{0,         1, 16383,  1, 1};
    tbl[9]  = '{16,        1, 1,      0, 0};
    tbl[10] = '{-16,       1, -2,     0, 0};
    tbl[11] = '{-17,       1, -1,     0, 1};
    tbl[12] = '{262111,    1, 16383,  0, 0};
    tbl[13] = '{262127,    1, 1,      0, 0};
    tbl[14] = '{524271,    1, 16383,  1, 0};
    tbl[15] = '{262127,    1, -16384, 0, 0};
    tbl[16] = '{-18,       1, -16384, 1, 1};

    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1; b1.clr_overrun = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1; b4.clr_overrun = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_u1_valid",   int'(b1.out_valid),   0);
    chk("rst_u1_data",    int'(b1.out_data),    0);
    chk("rst_u1_sat",     int'(b1.out_sat),     0);
    chk("rst_u1_inexact", int'(b1.out_inexact), 0);
    chk("rst_u1_overrun", int'(b1.overrun),     0);
    chk("rst_u4_valid",   int'(b4.out_valid),   0);
    chk("rst_u4_overrun", int'(b4.overrun),     0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: priming, differencing, inexact, saturation and range boundaries.
    for (int i = 0; i < 17; i++) begin
      drive(0, 1'b1, tbl[i].s);
      chk($sformatf("vec%0d_valid", i), int'(b1.out_valid), int'(tbl[i].has));
      if (tbl[i].has) begin
        chk($sformatf("vec%0d_data", i),    int'(b1.out_data),    tbl[i].data);
        chk($sformatf("vec%0d_sat", i),     int'(b1.out_sat),     int'(tbl[i].sat));
        chk($sformatf("vec%0d_inexact", i), int'(b1.out_inexact), int'(tbl[i].inex));
      end
    end
    drive(0, 1'b0, 0);
    chk("u1_drained_valid", int'(b1.out_valid), 0);

    // Backpressure: second result overwrites the first and sets overrun.
    b1.out_ready = 1'b0;
    drive(0, 1'b1, 14);
    chk("bp1_data", int'(b1.out_data), 2);
    chk("bp1_overrun", int'(b1.overrun), 0);
    drive(0, 1'b1, 62);
    sb0.delete(0);
    chk("bp2_valid", int'(b1.out_valid), 1);
    chk("bp2_data", int'(b1.out_data), 3);
    chk("bp2_overrun", int'(b1.overrun), 1);
    drive(0, 1'b0, 0);
    chk("hold_valid", int'(b1.out_valid), 1);
    chk("hold_data", int'(b1.out_data), 3);
    b1.out_ready = 1'b1;
    drive(0, 1'b0, 0);
    chk("hs_valid_clear", int'(b1.out_valid), 0);
    chk("overrun_sticky", int'(b1.overrun), 1);
    b1.clr_overrun = 1'b1;
    drive(0, 1'b0, 0);
    b1.clr_overrun = 1'b0;
    chk("overrun_cleared", int'(b1.overrun), 0);

    // Handshake coincident with a new result: no overrun.
    b1.out_ready = 1'b0;
    drive(0, 1'b1, 78);
    chk("coin1_data", int'(b1.out_data), 1);
    b1.out_ready = 1'b1;
    drive(0, 1'b1, 110);
    chk("coin2_valid", int'(b1.out_valid), 1);
    chk("coin2_data", int'(b1.out_data), 2);
    chk("coin2_overrun", int'(b1.overrun), 0);
    drive(0, 1'b0, 0);

    // Clear coincident with a new overrun: set wins.
    b1.out_ready = 1'b0;
    drive(0, 1'b1, 126);
    b1.clr_overrun = 1'b1;
    drive(0, 1'b1, 174);
    b1.clr_overrun = 1'b0;
    sb0.delete(0);
    chk("setwins_data", int'(b1.out_data), 3);
    chk("setwins_overrun", int'(b1.overrun), 1);
    b1.out_ready = 1'b1;
    drive(0, 1'b0, 0);
    b1.clr_overrun = 1'b1;
    drive(0, 1'b0, 0);
    b1.clr_overrun = 1'b0;
    chk("final_u1_overrun", int'(b1.overrun), 0);

    // Decimation by 4 on a +16 ramp with random input gaps.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) drive(1, 1'b0, 0);
      drive(1, 1'b1, 16 * i);
      tap = ((i % 4) == 3);
      chk($sformatf("dec%0d_valid", i), int'(b4.out_valid), int'(tap && i >= 7));
      if (tap && i >= 7) chk($sformatf("dec%0d_data", i), int'(b4.out_data), 4);
    end
    drive(1, 1'b0, 0);

    // Reset mid-operation with a held result and cnt == 2.
    b4.out_ready = 1'b0;
    for (int i = 16; i < 20; i++) drive(1, 1'b1, 16 * i);
    chk("pre_rst_valid", int'(b4.out_valid), 1);
    chk("pre_rst_data", int'(b4.out_data), 4);
    drive(1, 1'b1, 320);
    drive(1, 1'b1, 336);
    chk("pre_rst_hold", int'(b4.out_data), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid",   int'(b4.out_valid),   0);
    chk("arst_data",    int'(b4.out_data),    0);
    chk("arst_sat",     int'(b4.out_sat),     0);
    chk("arst_inexact", int'(b4.out_inexact), 0);
    chk("arst_overrun", int'(b4.overrun),     0);
    sb0.delete();
    sb1.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    s4 = 1000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, s4);
      chk($sformatf("reprime%0d_valid", i), int'(b4.out_valid), 0);
      s4 += 1000;
    end
    drive(1, 1'b1, 4016);
    drive(1, 1'b1, 4032);
    drive(1, 1'b1, 4048);
    drive(1, 1'b1, 4080);
    chk("post_rst_valid", int'(b4.out_valid), 1);
    chk("post_rst_data", int'(b4.out_data), 5);
    drive(1, 1'b0, 0);
    drive(0, 1'b0, 0);

    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
